// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state type, default widths and timeout read value for mem_arbiter
package mem_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam logic [63:0] TMO_RDATA = '1;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and memory-side buses of mem_arbiter
interface mem_arbiter_if import mem_arb_pkg::*; #(
  parameter int N_REQ = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [N_REQ-1:0] req, we, ready, gnt;
  logic [N_REQ*ADDR_W-1:0] addr;
  logic [N_REQ*DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_req, mem_we, mem_ready, busy, err;
  modport slave (
    input req, we, addr, wdata, mem_ready, mem_rdata,
    output ready, rdata, mem_req, mem_we, mem_addr, mem_wdata, gnt, busy, err
  );
  modport master (
    output req, we, addr, wdata, mem_ready, mem_rdata,
    input ready, rdata, mem_req, mem_we, mem_addr, mem_wdata, gnt, busy, err
  );
endinterface

// File: rtl/mem_arb_rr_pick.sv
// mem_arb_rr_pick: combinational round-robin picker searching from last+1
module mem_arb_rr_pick #(
  parameter int N_REQ = 2,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic [N_REQ-1:0] win,
  output logic [IW-1:0]    win_idx,
  output logic             any
);
  // scan from farthest to nearest so the first requester after last wins
  always_comb begin
    win_idx = '0;
    for (int k = N_REQ; k >= 1; k--)
      if (req[(int'(last) + k) % N_REQ]) win_idx = IW'((int'(last) + k) % N_REQ);
  end
  assign any = |req;
  assign win = any ? N_REQ'(1) << win_idx : '0;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory port; MEM_ARB_TIMEOUT_EN adds a BUSY watchdog with sticky err
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int N_REQ = 2,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  arb_state_e state;
  logic [IW-1:0] last, g, win_idx;
  logic [N_REQ-1:0] win;
  logic any, tmo, done;
  mem_arb_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req(bus.req),
    .last(last),
    .win(win),
    .win_idx(win_idx),
    .any(any)
  );
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1) > 8 ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt;
  logic err_q;
  assign tmo = state == ARB_BUSY && !bus.mem_ready && cnt == CW'(TIMEOUT);
  // count BUSY cycles from zero at entry and latch a sticky error on forced completion
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      err_q <= 1'b0;
    end else begin
      cnt <= state == ARB_BUSY ? cnt + 1'b1 : '0;
      err_q <= err_q | tmo;
    end
  assign bus.err = err_q;
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo = 1'b0;
  assign bus.err = 1'b0;
`endif
  assign done = state == ARB_BUSY && (bus.mem_ready || tmo);
  assign bus.ready = done ? bus.gnt : '0;
  assign bus.rdata = done ? (tmo ? DATA_W'(TMO_RDATA) : bus.mem_rdata) : '0;
  // grant from IDLE, latch the winner's command, hold it until completion
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ARB_IDLE;
      last <= IW'(N_REQ - 1);
      g <= '0;
      bus.gnt <= '0;
      bus.mem_req <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.busy <= 1'b0;
    end else if (state == ARB_IDLE) begin
      if (any) begin
        state <= ARB_BUSY;
        g <= win_idx;
        bus.gnt <= win;
        bus.mem_req <= 1'b1;
        bus.mem_we <= bus.we[win_idx];
        bus.mem_addr <= bus.addr[win_idx*ADDR_W +: ADDR_W];
        bus.mem_wdata <= bus.wdata[win_idx*DATA_W +: DATA_W];
        bus.busy <= 1'b1;
      end
    end else if (done) begin
      state <= ARB_IDLE;
      last <= g;
      bus.gnt <= '0;
      bus.mem_req <= 1'b0;
      bus.busy <= 1'b0;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter (timeout case follows MEM_ARB_TIMEOUT_EN)
module tb_mem_arbiter;
  timeunit 1ns;
  timeprecision 1ns;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif
  typedef struct {
    int idx;
    logic we;
    logic [7:0] addr, wdata, rdata;
    int bcyc;
  } exp_t;
  typedef struct {
    logic we;
    logic [7:0] addr, addr2, wdata;
  } cmd_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  mem_arbiter_if #(.N_REQ(2), .ADDR_W(8), .DATA_W(8)) bus ();
  mem_arbiter #(.N_REQ(2), .ADDR_W(8), .DATA_W(8), .TIMEOUT(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  exp_t sb[$];
  cmd_t cq[2][$];
  cmd_t c;
  logic [7:0] mem [256];
  logic [7:0] a2 [2];
  logic [1:0] drop, rdy_seen;
  int n_chk = 0, n_fail = 0;
  int lat = 0, mcnt = 0, cyc = 0, last_done = 0, last_gap = 0, busy_cyc = 0;
  bit mem_never = 0, prev_mreq = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic push(input int i, input logic we, input logic [7:0] a, input logic [7:0] aa,
                      input logic [7:0] wd, input int bc, input bit tmo);
    sb.push_back('{i, we, a, wd, tmo ? 8'hFF : mem[a], bc});
    cq[i].push_back('{we, a, aa, wd});
  endtask
  task automatic drain(input int max);
    for (int k = 0; k < max && sb.size() != 0; k++) @(negedge clk);
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  // requesters and memory model: drive all DUT inputs just after each rising edge
  always @(posedge clk) begin
    #1;
    if (rst) begin
      bus.req = '0;
      bus.we = '0;
      bus.addr = '0;
      bus.wdata = '0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      mcnt = 0;
      drop = '0;
      for (int i = 0; i < 2; i++) cq[i].delete();
    end else begin
      bus.mem_ready = bus.mem_req && !mem_never && mcnt == lat;
      bus.mem_rdata = bus.mem_ready ? mem[bus.mem_addr] : 8'($urandom);
      mcnt = bus.mem_req ? mcnt + 1 : 0;
      for (int i = 0; i < 2; i++)
        if (bus.req[i] && rdy_seen[i]) begin
          bus.req[i] = 1'b0;
          drop[i] = 1'b1;
        end else if (!bus.req[i] && !drop[i] && cq[i].size() != 0) begin
          c = cq[i].pop_front();
          bus.req[i] = 1'b1;
          bus.we[i] = c.we;
          bus.addr[i*8 +: 8] = c.addr;
          bus.wdata[i*8 +: 8] = c.wdata;
          a2[i] = c.addr2;
        end else begin
          drop[i] = 1'b0;
          if (bus.req[i] && bus.gnt[i]) bus.addr[i*8 +: 8] = a2[i];
        end
    end
  end
  // monitor: compare grants, held command and completions against the scoreboard
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_mreq = 1'b0;
      rdy_seen = '0;
    end else begin
      rdy_seen = bus.ready;
      if (bus.mem_req) begin
        if (sb.size() == 0) chk("grant_unexpected", 1, 0);
        else begin
          if (!prev_mreq) begin
            chk("gnt", bus.gnt, 32'(1) << sb[0].idx);
            chk("mem_we", bus.mem_we, sb[0].we);
            if (sb[0].we) chk("mem_wdata", bus.mem_wdata, sb[0].wdata);
            last_gap = cyc - last_done;
            busy_cyc = 0;
          end
          chk("mem_addr_held", bus.mem_addr, sb[0].addr);
        end
      end
      if (|bus.ready) begin
        if (sb.size() == 0) chk("ready_unexpected", bus.ready, 0);
        else begin
          chk("ready", bus.ready, 32'(1) << sb[0].idx);
          chk("rdata", bus.rdata, sb[0].rdata);
          if (sb[0].bcyc >= 0) chk("busy_cycles", busy_cyc, sb[0].bcyc);
          void'(sb.pop_front());
          last_done = cyc;
        end
      end else chk("rdata_idle", bus.rdata, 0);
      if (bus.mem_req) busy_cyc++;
      prev_mreq = bus.mem_req;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'(a) ^ 8'h3C;
    mem[8'h12] = 8'hA5;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_ready", bus.ready, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    rst = 1'b0;
    // single read with three-cycle memory latency
    lat = 3;
    push(0, 1'b0, 8'h12, 8'h12, 8'h00, 3, 0);
    @(negedge clk);
    chk("lat_cycle0_mem_req", bus.mem_req, 0);
    @(negedge clk);
    chk("lat_cycle1_mem_req", bus.mem_req, 1);
    chk("lat_cycle1_mem_addr", bus.mem_addr, 8'h12);
    drain(50);
    // simultaneous requests right after reset
    do_reset();
    lat = 1;
    push(0, 1'b1, 8'h04, 8'h04, 8'h33, 1, 0);
    push(1, 1'b0, 8'h10, 8'h10, 8'h00, 1, 0);
    drain(50);
    chk("idle_gap", last_gap, 2);
    // fairness with both requesters always busy
    do_reset();
    lat = 0;
    for (int k = 0; k < 3; k++) begin
      push(0, 1'b0, 8'h40 + 8'(k), 8'h40 + 8'(k), 8'h00, 0, 0);
      push(1, 1'b1, 8'h50 + 8'(k), 8'h50 + 8'(k), 8'h60 + 8'(k), 0, 0);
    end
    drain(100);
    // address change while granted must not reach the memory port
    do_reset();
    lat = 3;
    push(0, 1'b0, 8'h20, 8'h21, 8'h00, 3, 0);
    drain(50);
    // unanswered memory request
    do_reset();
    mem_never = 1;
`ifdef MEM_ARB_TIMEOUT_EN
    push(0, 1'b0, 8'h30, 8'h30, 8'h00, TMO, 1);
    drain(50);
    chk("tmo_err", bus.err, 1);
    chk("tmo_mem_req", bus.mem_req, 0);
    chk("tmo_busy", bus.busy, 0);
`else
    push(0, 1'b0, 8'h30, 8'h30, 8'h00, -1, 0);
    repeat (300) @(negedge clk);
    chk("hang_busy", bus.busy, 1);
    chk("hang_mem_req", bus.mem_req, 1);
    chk("hang_ready", bus.ready, 0);
    chk("hang_err", bus.err, 0);
`endif
    // reset in the middle of a transaction
    do_reset();
    push(0, 1'b0, 8'h70, 8'h70, 8'h00, -1, 0);
    for (int k = 0; k < 20 && !bus.busy; k++) @(negedge clk);
    chk("mid_rst_busy_before", bus.busy, 1);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_mem_req", bus.mem_req, 0);
    chk("mid_rst_gnt", bus.gnt, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ready", bus.ready, 0);
    chk("mid_rst_err", bus.err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mem_never = 0;
    lat = 1;
    push(0, 1'b0, 8'h71, 8'h71, 8'h00, 1, 0);
    push(1, 1'b0, 8'h72, 8'h72, 8'h00, 1, 0);
    drain(50);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
